// File: rtl/m_gen_sec.sv
`default_nettype none
// ============================================================================
// Module      : m_gen_sec
// Description : Centisecond/second stage of the stopwatch timebase. Divides
//               clk down to a centisecond tick, counts BCD 00.00 .. 59.99,
//               owns the run/pause/clear control state and emits clk_min,
//               whose single rising edge per minute clocks the minutes stage.
// Revision    : 1.0 - initial release
// ============================================================================
module m_gen_sec #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    output logic       running,
    output logic       tick,
    output logic [3:0] cs_low,
    output logic [3:0] cs_high,
    output logic [3:0] sec_low,
    output logic [3:0] sec_high,
    output logic       clk_min
);

    // Clock cycles per centisecond; CLK_HZ must be an integer multiple of
    // TICK_HZ and the ratio at least 2.
    localparam int c_div     = CLK_HZ / TICK_HZ;
    localparam int c_presc_w = (c_div > 1) ? $clog2(c_div) : 1;

    localparam logic [c_presc_w-1:0] c_presc_max  = c_presc_w'(c_div - 1);
    localparam logic [c_presc_w-1:0] c_presc_zero = '0;
    localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);

    // Control state encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_running;
    logic                   r_tick;
    logic [c_presc_w-1:0]   r_presc;
    logic [3:0]             r_cs_low;
    logic [3:0]             r_cs_high;
    logic [3:0]             r_sec_low;
    logic [3:0]             r_sec_high;
    logic                   r_clk_min;

    // Prescaler advances only in RUN and only when no start_stop arrives in
    // the same cycle: this gives zero pause latency (a tick due on the pause
    // edge is suppressed) and no advance on the resume edge, so the frozen
    // phase is picked up exactly where it stopped.
    logic w_in_run;
    logic w_advance;
    logic w_tick_now;
    logic w_clear_now;

    assign w_in_run    = (r_state == S_RUN);
    assign w_advance   = w_in_run && !start_stop;
    assign w_tick_now  = w_advance && (r_presc == c_presc_max);
    // Clear only acts while stopped; in RUN it is ignored entirely.
    assign w_clear_now = clear && !w_in_run;

    // Chained BCD increment of the four digits. Comparisons use >= so that
    // an out-of-range value can never propagate further.
    logic [3:0] w_cs_low_nx;
    logic [3:0] w_cs_high_nx;
    logic [3:0] w_sec_low_nx;
    logic [3:0] w_sec_high_nx;
    logic       w_carry_cs_low;
    logic       w_carry_cs_high;
    logic       w_carry_sec_low;
    logic       w_minute_wrap;

    // Next digit values assuming the current cycle is a tick
    always_comb begin
        w_cs_low_nx     = r_cs_low;
        w_cs_high_nx    = r_cs_high;
        w_sec_low_nx    = r_sec_low;
        w_sec_high_nx   = r_sec_high;
        w_carry_cs_low  = 1'b0;
        w_carry_cs_high = 1'b0;
        w_carry_sec_low = 1'b0;
        w_minute_wrap   = 1'b0;

        if (r_cs_low >= 4'd9) begin
            w_cs_low_nx    = 4'd0;
            w_carry_cs_low = 1'b1;
        end else begin
            w_cs_low_nx = r_cs_low + 4'd1;
        end

        if (w_carry_cs_low) begin
            if (r_cs_high >= 4'd9) begin
                w_cs_high_nx    = 4'd0;
                w_carry_cs_high = 1'b1;
            end else begin
                w_cs_high_nx = r_cs_high + 4'd1;
            end
        end

        if (w_carry_cs_high) begin
            if (r_sec_low >= 4'd9) begin
                w_sec_low_nx    = 4'd0;
                w_carry_sec_low = 1'b1;
            end else begin
                w_sec_low_nx = r_sec_low + 4'd1;
            end
        end

        if (w_carry_sec_low) begin
            if (r_sec_high >= 4'd5) begin
                w_sec_high_nx = 4'd0;
                w_minute_wrap = 1'b1;
            end else begin
                w_sec_high_nx = r_sec_high + 4'd1;
            end
        end
    end

    // Run/pause/clear control state with registered running flag.
    // Clear beats start_stop when stopped; start_stop beats clear in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end else if (start_stop) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start_stop) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (clear) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end else if (start_stop) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler and registered tick pulse
    always_ff @(posedge clk) begin
        if (rst || w_clear_now) begin
            r_presc <= c_presc_zero;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_tick_now;
            if (w_advance) begin
                if (r_presc == c_presc_max) begin
                    r_presc <= c_presc_zero;
                end else begin
                    r_presc <= r_presc + c_presc_one;
                end
            end
        end
    end

    // BCD digit registers; they change only on tick edges
    always_ff @(posedge clk) begin
        if (rst || w_clear_now) begin
            r_cs_low   <= 4'd0;
            r_cs_high  <= 4'd0;
            r_sec_low  <= 4'd0;
            r_sec_high <= 4'd0;
        end else if (w_tick_now) begin
            r_cs_low   <= w_cs_low_nx;
            r_cs_high  <= w_cs_high_nx;
            r_sec_low  <= w_sec_low_nx;
            r_sec_high <= w_sec_high_nx;
        end
    end

    // Minute strobe: set on the 59.99 -> 00.00 tick, dropped on the next
    // tick, held otherwise (including through PAUSE)
    always_ff @(posedge clk) begin
        if (rst || w_clear_now) begin
            r_clk_min <= 1'b0;
        end else if (w_tick_now) begin
            r_clk_min <= w_minute_wrap;
        end
    end

    assign running  = r_running;
    assign tick     = r_tick;
    assign cs_low   = r_cs_low;
    assign cs_high  = r_cs_high;
    assign sec_low  = r_sec_low;
    assign sec_high = r_sec_high;
    assign clk_min  = r_clk_min;

endmodule
`default_nettype wire
